// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Divisor arithmetic is done at a fixed wide width so any CNT_W up to CNT_W_MAX fits.
package clkdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W_MAX = 32;
    localparam logic [31:0] DIV_MIN = 32'd2;

    // One extra bit keeps div = 2^CNT_W-1 from overflowing when adding one.
    function automatic logic [CNT_W_MAX:0] hi_len(input logic [CNT_W_MAX:0] div);
        return (div + (CNT_W_MAX+1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided square wave, period-start tick,
// and a divisor reload that only takes effect on a period boundary.
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] phase,
    output logic             pend,
    output logic             err
);

    localparam int PAD_W = CNT_W_MAX + 1 - CNT_W;

    function automatic logic [CNT_W_MAX:0] widen(input logic [CNT_W-1:0] v);
        return {{PAD_W{1'b0}}, v};
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_s;
    logic             pend_s;
    logic             load_ok_s;
    logic             wrap_s;
    logic             clk_out_s;
    logic             tick_s;
    logic             err_s;

    assign phase = cnt_r;

    // Next-state counter, divisor and load bookkeeping.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        div_s      = div_r;
        pend_div_s = pend_div_r;
        pend_s     = pend;
        load_ok_s  = div_load && (div_value >= CNT_W'(DIV_MIN));
        err_s      = div_load && !load_ok_s;
        wrap_s     = (cnt_r == (div_r - CNT_W'(1)));

        case (state_r)
            IDLE: begin
                cnt_s  = '0;
                pend_s = 1'b0;
                if (load_ok_s) begin
                    div_s = div_value;
                end else begin
                    div_s = div_r;
                end
                if (en) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // Leaving RUN and wrapping are both period boundaries: commit any divisor.
                if (!en || wrap_s) begin
                    state_s = en ? RUN : IDLE;
                    cnt_s   = '0;
                    pend_s  = 1'b0;
                    if (load_ok_s) begin
                        div_s = div_value;
                    end else if (pend) begin
                        div_s = pend_div_r;
                    end else begin
                        div_s = div_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    if (load_ok_s) begin
                        pend_div_s = div_value;
                        pend_s     = 1'b1;
                    end else begin
                        pend_div_s = pend_div_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                pend_s  = 1'b0;
            end
        endcase

        clk_out_s = (state_s == RUN) && (widen(cnt_s) < hi_len(widen(div_s)));
        tick_s    = (state_s == RUN) && (cnt_s == '0);
    end

    // State, counter, divisor and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            div_r      <= CNT_W'(DEFAULT_DIV);
            pend_div_r <= '0;
            pend       <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            div_r      <= div_s;
            pend_div_r <= pend_div_s;
            pend       <= pend_s;
            clk_out    <= clk_out_s;
            tick       <= tick_s;
            err        <= err_s;
        end
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog built with DEFAULT_DIV = 4.
module tb_clock_divider_prog;

    localparam int CNT_W = 28;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_value = '0;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] phase;
    logic             pend;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_value(div_value),
        .clk_out(clk_out), .tick(tick), .phase(phase), .pend(pend), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        en = 1'b0; div_load = 1'b0; div_value = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; div_load = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({phase, clk_out, tick, pend, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got phase=%0d clk_out=%0b tick=%0b pend=%0b err=%0b, want all 0",
                     phase, clk_out, tick, pend, err);
        end
        en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_run_div4();
        apply_reset();
        en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            int ph = i % 4;
            n_checks++;
            if ({phase, clk_out, tick, pend, err} !== {CNT_W'(ph), ph < 2, ph == 0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL run_div4[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want phase=%0d clk_out=%0b tick=%0b pend=0",
                         i, phase, clk_out, tick, pend, ph, ph < 2, ph == 0);
            end
            step();
        end
    endtask

    task automatic test_load_mid();
        apply_reset();
        en = 1'b1;
        step();
        step();
        div_load = 1'b1; div_value = CNT_W'(6);
        step();
        div_load = 1'b0;
        n_checks++;
        if ({phase, pend, err} !== {CNT_W'(2), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_mid_pend: got phase=%0d pend=%0b err=%0b, want phase=2 pend=1 err=0", phase, pend, err);
        end
        step();
        n_checks++;
        if ({phase, pend} !== {CNT_W'(3), 1'b1}) begin
            n_fail++;
            $display("FAIL load_mid_hold: got phase=%0d pend=%0b, want phase=3 pend=1", phase, pend);
        end
        step();
        for (int i = 0; i < 7; i++) begin
            int ph = i % 6;
            n_checks++;
            if ({phase, clk_out, tick, pend, err} !== {CNT_W'(ph), ph < 3, ph == 0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL load_mid_div6[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want phase=%0d clk_out=%0b tick=%0b pend=0",
                         i, phase, clk_out, tick, pend, ph, ph < 3, ph == 0);
            end
            step();
        end
    endtask

    task automatic test_load_wrap();
        apply_reset();
        en = 1'b1;
        step();
        step(); step(); step();
        n_checks++;
        if (phase !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL load_wrap_phase: got phase=%0d, want 3", phase);
        end
        div_load = 1'b1; div_value = CNT_W'(5);
        step();
        div_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int ph = i % 5;
            n_checks++;
            if ({phase, clk_out, tick, pend, err} !== {CNT_W'(ph), ph < 3, ph == 0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL load_wrap_div5[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want phase=%0d clk_out=%0b tick=%0b pend=0",
                         i, phase, clk_out, tick, pend, ph, ph < 3, ph == 0);
            end
            step();
        end
    endtask

    task automatic test_err();
        apply_reset();
        en = 1'b1;
        step();
        div_load = 1'b1; div_value = CNT_W'(1);
        step();
        n_checks++;
        if ({phase, pend, err} !== {CNT_W'(1), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL err_div1: got phase=%0d pend=%0b err=%0b, want phase=1 pend=0 err=1", phase, pend, err);
        end
        div_value = CNT_W'(0);
        step();
        n_checks++;
        if ({phase, pend, err} !== {CNT_W'(2), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL err_div0: got phase=%0d pend=%0b err=%0b, want phase=2 pend=0 err=1", phase, pend, err);
        end
        div_load = 1'b0;
        step();
        n_checks++;
        if ({phase, pend, err} !== {CNT_W'(3), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL err_clear: got phase=%0d pend=%0b err=%0b, want phase=3 pend=0 err=0", phase, pend, err);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            int ph = i % 4;
            n_checks++;
            if ({phase, clk_out, tick, pend, err} !== {CNT_W'(ph), ph < 2, ph == 0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL err_keep_div4[%0d]: got phase=%0d clk_out=%0b tick=%0b, want phase=%0d clk_out=%0b tick=%0b",
                         i, phase, clk_out, tick, ph, ph < 2, ph == 0);
            end
            step();
        end
    endtask

    task automatic test_stop_pending();
        apply_reset();
        en = 1'b1;
        step();
        div_load = 1'b1; div_value = CNT_W'(8);
        step();
        div_load = 1'b0;
        step();
        n_checks++;
        if ({phase, pend} !== {CNT_W'(2), 1'b1}) begin
            n_fail++;
            $display("FAIL stop_pre: got phase=%0d pend=%0b, want phase=2 pend=1", phase, pend);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({phase, clk_out, tick, pend} !== {CNT_W'(0), 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stop_idle[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want all 0",
                         i, phase, clk_out, tick, pend);
            end
        end
        en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            int ph = i % 8;
            n_checks++;
            if ({phase, clk_out, tick, pend, err} !== {CNT_W'(ph), ph < 4, ph == 0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stop_div8[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want phase=%0d clk_out=%0b tick=%0b pend=0",
                         i, phase, clk_out, tick, pend, ph, ph < 4, ph == 0);
            end
            step();
        end
    endtask

    task automatic test_div_small();
        for (int d = 2; d <= 3; d++) begin
            apply_reset();
            div_load = 1'b1; div_value = CNT_W'(d);
            step();
            div_load = 1'b0;
            n_checks++;
            if ({phase, clk_out, tick, pend, err} !== '0) begin
                n_fail++;
                $display("FAIL idle_load_div%0d: got phase=%0d clk_out=%0b tick=%0b pend=%0b err=%0b, want all 0",
                         d, phase, clk_out, tick, pend, err);
            end
            en = 1'b1;
            step();
            for (int i = 0; i < 6; i++) begin
                int ph = i % d;
                n_checks++;
                if ({phase, clk_out, tick} !== {CNT_W'(ph), ph < (d + 1) / 2, ph == 0}) begin
                    n_fail++;
                    $display("FAIL div%0d[%0d]: got phase=%0d clk_out=%0b tick=%0b, want phase=%0d clk_out=%0b tick=%0b",
                             d, i, phase, clk_out, tick, ph, ph < (d + 1) / 2, ph == 0);
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        en = 1'b1;
        step();
        div_load = 1'b1; div_value = CNT_W'(6);
        step();
        div_value = CNT_W'(7);
        step();
        div_load = 1'b0;
        n_checks++;
        if ({phase, pend, err} !== {CNT_W'(2), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_pend: got phase=%0d pend=%0b err=%0b, want phase=2 pend=1 err=0", phase, pend, err);
        end
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            int ph = i % 7;
            n_checks++;
            if ({phase, clk_out, tick, pend} !== {CNT_W'(ph), ph < 4, ph == 0, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_div7[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want phase=%0d clk_out=%0b tick=%0b pend=0",
                         i, phase, clk_out, tick, pend, ph, ph < 4, ph == 0);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; div_load = 1'b1; div_value = CNT_W'(6);
        step();
        div_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int ph = i % 6;
            n_checks++;
            if ({phase, clk_out, tick, pend} !== {CNT_W'(ph), ph < 3, ph == 0, 1'b0}) begin
                n_fail++;
                $display("FAIL same_cycle_div6[%0d]: got phase=%0d clk_out=%0b tick=%0b pend=%0b, want phase=%0d clk_out=%0b tick=%0b pend=0",
                         i, phase, clk_out, tick, pend, ph, ph < 3, ph == 0);
            end
            step();
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({phase, clk_out, tick, pend, err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got phase=%0d clk_out=%0b tick=%0b pend=%0b err=%0b, want all 0",
                     phase, clk_out, tick, pend, err);
        end
        #1 rst = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            int ph = i % 4;
            n_checks++;
            if ({phase, clk_out, tick} !== {CNT_W'(ph), ph < 2, ph == 0}) begin
                n_fail++;
                $display("FAIL post_reset_div4[%0d]: got phase=%0d clk_out=%0b tick=%0b, want phase=%0d clk_out=%0b tick=%0b",
                         i, phase, clk_out, tick, ph, ph < 2, ph == 0);
            end
            step();
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_run_div4();
        test_load_mid();
        test_load_wrap();
        test_err();
        test_stop_pending();
        test_div_small();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
